// File: rtl/jt03_busq_mix.sv
// jt03_busq_mix: queues host register writes and replays them to a jt12_top with chip-safe spacing,
// and mixes FM/PSG audio with gain and saturation. Define JT03_DCBLOCK_EN to add a DC blocker stage.
//
// state    | meaning
// S_IDLE   | waiting for a queued write and a cen pulse
// S_STROBE | chip_cs_n/chip_wr_n low for one cen period
// S_GAP    | down-counting the post-write busy time
module jt03_busq_mix #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned AW         = 1,
  parameter int unsigned ADDR_GAP   = 17,
  parameter int unsigned DATA_GAP   = 83,
  parameter logic [7:0]  FM_GAIN    = 8'h10,
  parameter logic [7:0]  PSG_GAIN   = 8'h20,
  parameter int unsigned OUT_W      = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        i_cen,
  input  logic                        i_host_we,
  input  logic [AW-1:0]               i_host_addr,
  input  logic [7:0]                  i_host_din,
  output logic                        o_host_ready,
  output logic [$clog2(FIFO_DEPTH):0] o_fifo_level,
  output logic                        o_ovf,
  output logic                        o_chip_cs_n,
  output logic                        o_chip_wr_n,
  output logic [AW-1:0]               o_chip_addr,
  output logic [7:0]                  o_chip_din,
  input  logic signed [15:0]          i_fm_snd,
  input  logic [9:0]                  i_psg_snd,
  input  logic                        i_snd_sample,
  output logic signed [OUT_W-1:0]     o_snd,
  output logic                        o_snd_valid,
  output logic                        o_clip
);

  localparam int unsigned LW      = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W   = LW + 1;
  localparam int unsigned EW      = AW + 8;
  localparam int unsigned GAP_MAX = (DATA_GAP > ADDR_GAP) ? DATA_GAP : ADDR_GAP;
  localparam int unsigned GW      = (GAP_MAX < 1) ? 1 : $clog2(GAP_MAX + 1);
  localparam logic [GW-1:0] ADDR_GAP_C = GW'(ADDR_GAP);
  localparam logic [GW-1:0] DATA_GAP_C = GW'(DATA_GAP);

  typedef enum logic [1:0] {S_IDLE, S_STROBE, S_GAP} state_t;

  logic [EW-1:0]    r_mem [FIFO_DEPTH];
  logic [LW-1:0]    r_wptr, r_rptr;
  logic [LVL_W-1:0] r_level;
  logic             r_ovf;
  logic             w_full, w_push, w_pop;
  logic [EW-1:0]    w_head;

  state_t           r_state, w_state_nxt;
  logic [GW-1:0]    r_gap, w_gap_nxt;
  logic             r_strb_n;
  logic [AW-1:0]    r_chip_addr;
  logic [7:0]       r_chip_din;

  // full is judged on the registered level, so a pop in the same cycle never frees a slot for the push
  assign w_full = (r_level == LVL_W'(FIFO_DEPTH));
  assign w_push = i_host_we & ~w_full;
  assign w_head = r_mem[r_rptr];

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= {i_host_addr, i_host_din};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + LW'(1);
      if (w_pop)  r_rptr <= r_rptr + LW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
      if (i_host_we && w_full) r_ovf <= 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_gap_nxt   = r_gap;
    w_pop       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_cen && (r_level != '0)) begin
          w_pop       = 1'b1;
          w_state_nxt = S_STROBE;
        end
      end
      S_STROBE: begin
        if (i_cen) begin
          w_gap_nxt   = r_chip_addr[0] ? DATA_GAP_C : ADDR_GAP_C;
          w_state_nxt = S_GAP;
        end
      end
      S_GAP: begin
        // leaving on the 1->0 step makes the next strobe land gap+1 cen pulses after the last one ended
        if (i_cen) begin
          w_gap_nxt = (r_gap == '0) ? '0 : r_gap - GW'(1);
          if (r_gap <= GW'(1)) w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_gap       <= '0;
      r_strb_n    <= 1'b1;
      r_chip_addr <= '0;
      r_chip_din  <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_gap    <= w_gap_nxt;
      r_strb_n <= (w_state_nxt != S_STROBE);
      if (w_pop) begin
        r_chip_addr <= w_head[EW-1:8];
        r_chip_din  <= w_head[7:0];
      end
    end
  end

  assign o_host_ready = ~w_full;
  assign o_fifo_level = r_level;
  assign o_ovf        = r_ovf;
  assign o_chip_cs_n  = r_strb_n;
  assign o_chip_wr_n  = r_strb_n;
  assign o_chip_addr  = r_chip_addr;
  assign o_chip_din   = r_chip_din;

  localparam logic signed [25:0] FM_G    = $signed({18'd0, FM_GAIN});
  localparam logic signed [25:0] PSG_G   = $signed({18'd0, PSG_GAIN});
  localparam logic signed [25:0] SAT_MAX = (26'sd1 <<< (OUT_W - 1)) - 26'sd1;
  localparam logic signed [25:0] SAT_MIN = -(26'sd1 <<< (OUT_W - 1));

  logic signed [10:0]      w_psg_c;
  logic signed [25:0]      w_fm_ext, w_psg_ext, w_acc, w_y;
  logic signed [OUT_W-1:0] w_sat;
  logic                    w_sat_clip;
  logic signed [OUT_W-1:0] r_snd;
  logic                    r_snd_valid, r_clip;

  assign w_psg_c   = $signed({1'b0, i_psg_snd} - 11'd512);
  assign w_fm_ext  = {{10{i_fm_snd[15]}}, i_fm_snd};
  assign w_psg_ext = {{15{w_psg_c[10]}}, w_psg_c};
  assign w_acc     = w_fm_ext * FM_G + w_psg_ext * PSG_G * 26'sd64;
  assign w_y       = w_acc >>> 4;

  always_comb begin
    w_sat      = w_y[OUT_W-1:0];
    w_sat_clip = 1'b0;
    if (w_y > SAT_MAX) begin
      w_sat      = SAT_MAX[OUT_W-1:0];
      w_sat_clip = 1'b1;
    end else if (w_y < SAT_MIN) begin
      w_sat      = SAT_MIN[OUT_W-1:0];
      w_sat_clip = 1'b1;
    end
  end

`ifdef JT03_DCBLOCK_EN
  localparam int unsigned ZW = 22;
  localparam logic signed [ZW-1:0] Z_MAX = 22'sd524287;
  localparam logic signed [ZW-1:0] Z_MIN = -22'sd524288;
  localparam logic signed [ZW-1:0] O_MAX = (22'sd1 <<< (OUT_W - 1)) - 22'sd1;
  localparam logic signed [ZW-1:0] O_MIN = -(22'sd1 <<< (OUT_W - 1));

  logic                    r_s1_v, r_s1_clip;
  logic signed [OUT_W-1:0] r_s1_y, r_y_prev;
  logic signed [19:0]      r_z_prev;
  logic signed [ZW-1:0]    w_z;
  logic signed [19:0]      w_z_st;
  logic signed [OUT_W-1:0] w_z_out;
  logic                    w_z_clip;

  assign w_z = ZW'(r_s1_y) - ZW'(r_y_prev) + ZW'(r_z_prev) - ZW'(r_z_prev >>> 8);

  always_comb begin
    w_z_st   = w_z[19:0];
    w_z_out  = w_z[OUT_W-1:0];
    w_z_clip = 1'b0;
    if (w_z > Z_MAX)      w_z_st = Z_MAX[19:0];
    else if (w_z < Z_MIN) w_z_st = Z_MIN[19:0];
    if (w_z > O_MAX) begin
      w_z_out  = O_MAX[OUT_W-1:0];
      w_z_clip = 1'b1;
    end else if (w_z < O_MIN) begin
      w_z_out  = O_MIN[OUT_W-1:0];
      w_z_clip = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_v      <= 1'b0;
      r_s1_clip   <= 1'b0;
      r_s1_y      <= '0;
      r_y_prev    <= '0;
      r_z_prev    <= '0;
      r_snd       <= '0;
      r_snd_valid <= 1'b0;
      r_clip      <= 1'b0;
    end else begin
      r_s1_v <= i_snd_sample;
      if (i_snd_sample) begin
        r_s1_y    <= w_sat;
        r_s1_clip <= w_sat_clip;
      end
      r_snd_valid <= r_s1_v;
      r_clip      <= r_s1_v & (r_s1_clip | w_z_clip);
      if (r_s1_v) begin
        r_snd    <= w_z_out;
        r_y_prev <= r_s1_y;
        r_z_prev <= w_z_st;
      end
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_snd       <= '0;
      r_snd_valid <= 1'b0;
      r_clip      <= 1'b0;
    end else begin
      r_snd_valid <= i_snd_sample;
      r_clip      <= i_snd_sample & w_sat_clip;
      if (i_snd_sample) r_snd <= w_sat;
    end
  end
`endif

  assign o_snd       = r_snd;
  assign o_snd_valid = r_snd_valid;
  assign o_clip      = r_clip;

endmodule
